// File: rtl/qpsk_demodulator_if.sv
// Sample-in / decision-out bundle for qpsk_demodulator.
// Build option DEMOD_ERASURE_EN (in the demodulator) gives sym_erase a meaning; otherwise it reads 0.
interface qpsk_demodulator_if;
  // Valid-only flow, no backpressure: sample_valid qualifies wav_in and sym_sync in the same cycle;
  // sym_valid and bit_valid are single-cycle pulses, and sym_out/bit_out hold between pulses.
  logic       sample_valid;
  logic       sym_sync;
  logic [7:0] wav_in;
  logic [1:0] sym_out;
  logic       sym_valid;
  logic       bit_out;
  logic       bit_valid;
  logic       sym_erase;

  modport master (
    output sample_valid, sym_sync, wav_in,
    input  sym_out, sym_valid, bit_out, bit_valid, sym_erase
  );

  modport slave (
    input  sample_valid, sym_sync, wav_in,
    output sym_out, sym_valid, bit_out, bit_valid, sym_erase
  );
endinterface

// File: rtl/qpsk_demodulator.sv
// Coherent QPSK demodulator: correlates N unsigned sine samples against sin/cos references, decides a Gray symbol.
// Define DEMOD_ERASURE_EN to flag low-confidence decisions on sym_erase (max(|S|,|C|) < THRESH).
module qpsk_demodulator #(
  parameter int N     = 32,
  parameter int ACC_W = 21
`ifdef DEMOD_ERASURE_EN
  ,
  parameter int THRESH = 2048
`endif
) (
  input  logic                clk_fast,
  input  logic                rst,
  qpsk_demodulator_if.slave   dm,
  output logic [0:0]          dbg_state
);

  localparam int IDX_W    = $clog2(N);
  // The reference ROM is a 32-point sine; smaller power-of-2 N steps through it.
  localparam int LUT_STEP = 32 / N;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  // Quarter-wave table of round(127*sin(2*pi*i/32)); i[3] mirrors, i[4] negates.
  function automatic logic signed [7:0] sin_lut(input logic [4:0] i);
    logic [3:0] j;
    logic [6:0] m;
    j = i[3] ? (4'd8 - {1'b0, i[2:0]}) : {1'b0, i[2:0]};
    case (j)
      4'd0:    m = 7'd0;
      4'd1:    m = 7'd25;
      4'd2:    m = 7'd49;
      4'd3:    m = 7'd71;
      4'd4:    m = 7'd90;
      4'd5:    m = 7'd106;
      4'd6:    m = 7'd117;
      4'd7:    m = 7'd125;
      4'd8:    m = 7'd127;
      default: m = 7'd0;
    endcase
    sin_lut = i[4] ? -$signed({1'b0, m}) : $signed({1'b0, m});
  endfunction

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic signed [ACC_W-1:0]  s_acc_q, s_acc_d;
  logic signed [ACC_W-1:0]  c_acc_q, c_acc_d;
  logic [1:0]               sym_q, sym_d;
  logic                     sym_valid_q, sym_valid_d;
  logic                     bit_q, bit_d;
  logic                     bit_valid_q, bit_valid_d;
  logic                     lsb_pend_q, lsb_pend_d;

  logic [IDX_W-1:0]         eff_idx;
  logic [4:0]               lut_s_idx, lut_c_idx;
  logic signed [7:0]        x, r_s, r_c;
  logic signed [15:0]       p_s, p_c;
  logic signed [ACC_W-1:0]  p_s_ext, p_c_ext;
  logic                     fire;
  logic signed [ACC_W:0]    s_ext, c_ext;
  logic [ACC_W:0]           mag_s, mag_c;
  logic [1:0]               dec;

  // Datapath: centre the sample, fetch references for the effective index, multiply.
  always_comb begin
    eff_idx   = (state_q == IDLE || dm.sym_sync) ? '0 : idx_q;
    lut_s_idx = 5'(32'(eff_idx) * 32'(LUT_STEP));
    lut_c_idx = lut_s_idx + 5'd8;
    x         = $signed(dm.wav_in ^ 8'h80);
    r_s       = sin_lut(lut_s_idx);
    r_c       = sin_lut(lut_c_idx);
    p_s       = x * r_s;
    p_c       = x * r_c;
    p_s_ext   = {{(ACC_W-16){p_s[15]}}, p_s};
    p_c_ext   = {{(ACC_W-16){p_c[15]}}, p_c};
  end

  // Control: index 0 (natural wrap, IDLE or a sync) loads the accumulators instead of adding.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    s_acc_d = s_acc_q;
    c_acc_d = c_acc_q;
    fire    = 1'b0;
    if (dm.sample_valid) begin
      state_d = ACC;
      idx_d   = eff_idx + 1'b1;
      fire    = (eff_idx == IDX_W'(N - 1));
      if (eff_idx == '0) begin
        s_acc_d = p_s_ext;
        c_acc_d = p_c_ext;
      end else begin
        s_acc_d = s_acc_q + p_s_ext;
        c_acc_d = c_acc_q + p_c_ext;
      end
    end
  end

  // Decide on the final sums so the symbol registers on the edge that takes sample N-1.
  always_comb begin
    s_ext = {s_acc_d[ACC_W-1], s_acc_d};
    c_ext = {c_acc_d[ACC_W-1], c_acc_d};
    mag_s = s_ext[ACC_W] ? $unsigned(-s_ext) : $unsigned(s_ext);
    mag_c = c_ext[ACC_W] ? $unsigned(-c_ext) : $unsigned(c_ext);
    if (mag_s >= mag_c) begin
      dec = s_acc_d[ACC_W-1] ? 2'b11 : 2'b00;
    end else begin
      dec = c_acc_d[ACC_W-1] ? 2'b10 : 2'b01;
    end
  end

  // Output stage: MSB goes out with the decision, LSB the cycle after; a new decision wins.
  always_comb begin
    sym_d       = fire ? dec : sym_q;
    sym_valid_d = fire;
    bit_d       = bit_q;
    bit_valid_d = 1'b0;
    lsb_pend_d  = 1'b0;
    if (fire) begin
      bit_d       = dec[1];
      bit_valid_d = 1'b1;
      lsb_pend_d  = 1'b1;
    end else if (lsb_pend_q) begin
      bit_d       = sym_q[0];
      bit_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      s_acc_q     <= '0;
      c_acc_q     <= '0;
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
      bit_q       <= 1'b0;
      bit_valid_q <= 1'b0;
      lsb_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      s_acc_q     <= s_acc_d;
      c_acc_q     <= c_acc_d;
      sym_q       <= sym_d;
      sym_valid_q <= sym_valid_d;
      bit_q       <= bit_d;
      bit_valid_q <= bit_valid_d;
      lsb_pend_q  <= lsb_pend_d;
    end
  end

`ifdef DEMOD_ERASURE_EN
  logic [ACC_W:0] max_mag;
  logic           erase_q, erase_d;

  always_comb begin
    max_mag = (mag_s >= mag_c) ? mag_s : mag_c;
    erase_d = fire ? (max_mag < (ACC_W+1)'(THRESH)) : erase_q;
  end

  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      erase_q <= 1'b0;
    end else begin
      erase_q <= erase_d;
    end
  end

  assign dm.sym_erase = erase_q;
`else
  assign dm.sym_erase = 1'b0;
`endif

  assign dm.sym_out   = sym_q;
  assign dm.sym_valid = sym_valid_q;
  assign dm.bit_out   = bit_q;
  assign dm.bit_valid = bit_valid_q;
  assign dbg_state    = state_q;

endmodule
